letc_core_cache_port_arb: RTL and testbench
===========================================

# letc_core_cache_port_arb

- Parametrised, buffered request arbiter between `NUM_PORTS` LETC core requesters (e.g. fetch, memory stage, page-table walker) and one shared cache port.
- Arbitrates with valid/ready handshakes and registers the winning request toward the cache.
- Tracks outstanding requests in an in-order ID FIFO so each cache response returns to the port that issued it.
- Sits in `rtl/letc/core` between the pipeline stages and the L1 cache.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of requesting ports; 2..8.
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: write/read data width; multiple of 8.
- `MAX_OUTSTANDING`, 4: ID FIFO depth; power of two, 2..16.

Ports:
- `i_clk`  in  1: clock; all state updates on rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req_valid`  in  NUM_PORTS: per-port request valid.
- `o_req_ready`  out  NUM_PORTS: per-port accept; at most one bit high.
- `i_req_addr`  in  NUM_PORTS×ADDR_WIDTH: per-port address.
- `i_req_wen`  in  NUM_PORTS: 1 = write, 0 = read.
- `i_req_wdata`  in  NUM_PORTS×DATA_WIDTH: write data.
- `i_req_wmask`  in  NUM_PORTS×(DATA_WIDTH/8): byte enables.
- `o_cache_valid`  out  1: registered request valid toward cache.
- `i_cache_ready`  in  1: cache accepts request.
- `o_cache_addr`, `o_cache_wen`, `o_cache_wdata`, `o_cache_wmask`  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8: registered request fields.
- `i_cache_rsp_valid`  in  1: cache response (read data or write ack), in request order.
- `i_cache_rsp_rdata`  in  DATA_WIDTH: response data.
- `o_rsp_valid`  out  NUM_PORTS: one-hot response strobe to the owning port.
- `o_rsp_rdata`  out  DATA_WIDTH: response data, broadcast to all ports.

## Operation

- Every request, read or write, receives exactly one response.
- **Output register:** one entry holding `o_cache_*`. It is free when empty, or when `o_cache_valid & i_cache_ready` in the current cycle.
- **Accept condition** (combinational): output register free, ID FIFO count < `MAX_OUTSTANDING`, not in reset, and at least one `i_req_valid` set.
- **Grant:** when the accept condition holds, exactly one port is granted and `o_req_ready[grant]` is 1. `o_req_ready` may depend on `i_req_valid`.
- **On accept:**
  - the granted fields load into the output register;
  - the grant index is pushed into the ID FIFO;
  - the round-robin pointer moves to `(grant+1) mod NUM_PORTS`.
- **Arbitration:** round-robin. The first requesting port at or after the pointer, wrapping, wins. Reset pointer = 0.
- **Output drain:** the register clears when the cache takes it with no new accept that cycle. Accept and drain in the same cycle give back-to-back issue.
- **Responses:** `i_cache_rsp_valid` pops the FIFO head.
  - `o_rsp_valid` is the one-hot decode of the head when `i_cache_rsp_valid` is 1, otherwise 0.
  - `o_rsp_rdata = i_cache_rsp_rdata` (combinational pass-through).
- **Full FIFO:** a pop in the same cycle does not free a slot for that cycle's push. Accept stalls until the count drops below the depth.
- **Empty FIFO:** a response with an empty FIFO is dropped, with no pop and no `o_rsp_valid`. Under `SIMULATION` this is an assertion failure.
- **Simultaneous accept and response:** both push and pop occur, and the count is unchanged.
- **Reset mid-operation:** the output register, FIFO and pointer clear. Any in-flight cache responses after reset are treated as empty-FIFO responses. The cache is responsible for flushing them.

## Timing

- Reset values: `o_cache_valid` = 0, `o_cache_*` = 0, `o_req_ready` = 0, `o_rsp_valid` = 0, `o_rsp_rdata` = `i_cache_rsp_rdata`.
- Request latency: accepted in cycle N, presented with `o_cache_valid` = 1 in cycle N+1.
- Sustained throughput: 1 request/cycle while `i_cache_ready` = 1 and the FIFO has space.
- Response latency: 0 cycles; `o_rsp_valid` is in the same cycle as `i_cache_rsp_valid`.
- `o_cache_*` are held stable while `o_cache_valid & ~i_cache_ready`.

## Configuration

- Macro: `LETC_CACHE_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration with a rotating pointer, as above.
- Undefined: fixed priority, where the lowest-index requesting port always wins. The pointer register is removed; all other behaviour is identical.

## Test plan

- **Reset:** hold `i_rst` = 1 with all `i_req_valid` = 1 → all outputs 0 and no accept. Release → port 0 granted in the first cycle, `o_cache_valid` = 1 the next cycle.
- **Round-robin:** `NUM_PORTS` = 3, all ports valid, `i_cache_ready` = 1 → grants 0,1,2,0,1,2.
  - Same stimulus without the macro → grants 0,0,0…
- **Backpressure:** `i_cache_ready` = 0 for 5 cycles with the request at addr 0x1000 → `o_cache_addr` is stable at 0x1000. Every `o_req_ready` is 0 after the first accept. The request issues on the cycle `i_cache_ready` returns.
- **FIFO full:** `MAX_OUTSTANDING` = 4, cache always ready, no responses → exactly 4 accepts, then stall. One response → one more accept in the following cycle, not the same cycle.
- **Routing:**
  - Accept order port1, port0, port1.
  - Responses with rdata 0xA, 0xB, 0xC.
  - Required: `o_rsp_valid` = 0b10, 0b01, 0b10 with matching rdata.
- **Spurious response:** empty FIFO, `i_cache_rsp_valid` = 1 → `o_rsp_valid` = 0, FIFO count stays 0, and the simulation assertion fires.

Source files
------------

// File: rtl/letc_core_cache_port_arb.sv
// Buffered N-port request arbiter in front of the shared L1 cache port, with an in-order ID FIFO
// for response routing. Define LETC_CACHE_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module letc_core_cache_port_arb #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_PORTS-1:0]                  i_req_valid,
  output logic [NUM_PORTS-1:0]                  o_req_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       i_req_addr,
  input  logic [NUM_PORTS-1:0]                  i_req_wen,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       i_req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   i_req_wmask,
  output logic                                  o_cache_valid,
  input  logic                                  i_cache_ready,
  output logic [ADDR_WIDTH-1:0]                 o_cache_addr,
  output logic                                  o_cache_wen,
  output logic [DATA_WIDTH-1:0]                 o_cache_wdata,
  output logic [DATA_WIDTH/8-1:0]               o_cache_wmask,
  input  logic                                  i_cache_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                 i_cache_rsp_rdata,
  output logic [NUM_PORTS-1:0]                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0]                 o_rsp_rdata
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW = $clog2(MAX_OUTSTANDING);
  localparam int MW = DATA_WIDTH / 8;

  logic [PW-1:0] grant;
  logic          reg_free;
  logic          fifo_space;
  logic          accept;
  logic          push;
  logic          pop;

  logic                  cache_valid_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic                  cache_wen_q;
  logic [DATA_WIDTH-1:0] cache_wdata_q;
  logic [MW-1:0]         cache_wmask_q;

  logic [FW:0]   count_q, count_d;
  logic [FW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] id_mem_q [MAX_OUTSTANDING];

`ifdef LETC_CACHE_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!found && i_req_valid[PW'(idx)]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
  end

  assign rr_ptr_d = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (i_req_valid[PW'(k)]) grant = PW'(k);
    end
  end
`endif

  // Full check uses the registered count, so a same-cycle pop never frees a slot for a push.
  assign reg_free   = ~cache_valid_q | i_cache_ready;
  assign fifo_space = count_q < (FW+1)'(MAX_OUTSTANDING);
  assign accept     = reg_free & fifo_space & ~i_rst & (|i_req_valid);
  assign o_req_ready = accept ? (NUM_PORTS'(1) << grant) : '0;

  assign push = accept;
  assign pop  = i_cache_rsp_valid & ~i_rst & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FW+1)'(1);
      2'b01:   count_d = count_q - (FW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + FW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) id_mem_q[wr_ptr_q] <= grant;
  end

  assign o_rsp_valid = pop ? (NUM_PORTS'(1) << id_mem_q[rd_ptr_q]) : '0;
  assign o_rsp_rdata = i_cache_rsp_rdata;

  // Accept and drain in one cycle reloads the register for back-to-back issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_wen_q   <= 1'b0;
      cache_wdata_q <= '0;
      cache_wmask_q <= '0;
    end else if (accept) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= i_req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
      cache_wen_q   <= i_req_wen[grant];
      cache_wdata_q <= i_req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
      cache_wmask_q <= i_req_wmask[grant*MW +: MW];
    end else if (i_cache_ready) begin
      cache_valid_q <= 1'b0;
    end
  end

  assign o_cache_valid = cache_valid_q;
  assign o_cache_addr  = cache_addr_q;
  assign o_cache_wen   = cache_wen_q;
  assign o_cache_wdata = cache_wdata_q;
  assign o_cache_wmask = cache_wmask_q;

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_cache_rsp_valid) begin
      assert (count_q != '0) else $error("cache response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_letc_core_cache_port_arb.sv
// Directed, table-driven bench for letc_core_cache_port_arb with three ports and a 4-deep ID FIFO.
module tb_letc_core_cache_port_arb;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef LETC_CACHE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0]    req_wen;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*MW-1:0] req_wmask;
  logic             cache_valid;
  logic             cache_ready;
  logic [AW-1:0]    cache_addr;
  logic             cache_wen;
  logic [DW-1:0]    cache_wdata;
  logic [MW-1:0]    cache_wmask;
  logic             rsp_valid_in;
  logic [DW-1:0]    rsp_rdata_in;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  letc_core_cache_port_arb #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_cache_valid(cache_valid), .i_cache_ready(cache_ready),
    .o_cache_addr(cache_addr), .o_cache_wen(cache_wen),
    .o_cache_wdata(cache_wdata), .o_cache_wmask(cache_wmask),
    .i_cache_rsp_valid(rsp_valid_in), .i_cache_rsp_rdata(rsp_rdata_in),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] vld;
    logic          crdy;
    logic          rspv;
    logic [31:0]   rdata;
    logic [NP-1:0] xrdy;
    logic [NP-1:0] xrsp;
    logic          xcv;
    logic [31:0]   xaddr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, compare 1 ns later, then cross the rising edge.
  task automatic cyc(input string nm, input logic [NP-1:0] vld, input logic crdy,
                     input logic rspv, input logic [31:0] rdata,
                     input logic [NP-1:0] xrdy, input logic [NP-1:0] xrsp,
                     input logic xcv, input logic [31:0] xaddr);
    req_valid    = vld;
    cache_ready  = crdy;
    rsp_valid_in = rspv;
    rsp_rdata_in = rdata;
    #1;
    chk({nm, ".req_ready"},   32'(req_ready),   32'(xrdy));
    chk({nm, ".rsp_valid"},   32'(rsp_valid),   32'(xrsp));
    chk({nm, ".rsp_rdata"},   rsp_rdata,        rdata);
    chk({nm, ".cache_valid"}, 32'(cache_valid), 32'(xcv));
    chk({nm, ".cache_addr"},  cache_addr,       xaddr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '1;
    cache_ready  = 1'b1;
    rsp_valid_in = 1'b1;
    rsp_rdata_in = 32'h55;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.req_ready",   32'(req_ready),   32'h0);
    chk("rst.rsp_valid",   32'(rsp_valid),   32'h0);
    chk("rst.rsp_rdata",   rsp_rdata,        32'h55);
    chk("rst.cache_valid", 32'(cache_valid), 32'h0);
    chk("rst.cache_addr",  cache_addr,       32'h0);
    chk("rst.cache_wdata", cache_wdata,      32'h0);
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    rsp_valid_in = 1'b0;
    rsp_rdata_in = '0;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AW +: AW]  = 32'h1000 + 32'(p) * 32'h100;
      req_wdata[p*DW +: DW] = 32'hD0 + 32'(p);
      req_wmask[p*MW +: MW] = MW'(1) << p;
      req_wen[p]            = p[0];
    end
    rst = 1'b1; req_valid = '0; cache_ready = 1'b0; rsp_valid_in = 1'b0; rsp_rdata_in = '0;
    @(negedge clk);

    // Arbitration order, FIFO fill to depth, then one response frees exactly one slot a cycle later.
    tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b001,               3'b000, 1'b0, 32'h0};
    tbl[1] = '{3'b111, 1'b1, 1'b0, 32'h0,  RR ? 3'b010 : 3'b001, 3'b000, 1'b1, 32'h1000};
    tbl[2] = '{3'b111, 1'b1, 1'b0, 32'h0,  RR ? 3'b100 : 3'b001, 3'b000, 1'b1, RR ? 32'h1100 : 32'h1000};
    tbl[3] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b001,               3'b000, 1'b1, RR ? 32'h1200 : 32'h1000};
    tbl[4] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b000,               3'b000, 1'b1, 32'h1000};
    tbl[5] = '{3'b111, 1'b1, 1'b1, 32'hA,  3'b000,               3'b001, 1'b0, 32'h1000};
    tbl[6] = '{3'b111, 1'b1, 1'b0, 32'h0,  RR ? 3'b010 : 3'b001, 3'b000, 1'b0, 32'h1000};
    tbl[7] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b000,               3'b000, 1'b1, RR ? 32'h1100 : 32'h1000};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("arb%0d", i), tbl[i].vld, tbl[i].crdy, tbl[i].rspv, tbl[i].rdata,
          tbl[i].xrdy, tbl[i].xrsp, tbl[i].xcv, tbl[i].xaddr);
    end

    // Backpressure: the held request stays put and nothing else is accepted until the cache takes it.
    do_reset();
    cyc("bp.acc", 3'b001, 1'b0, 1'b0, 32'h0, 3'b001, 3'b000, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("bp.hold%0d", i), 3'b111, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000, 1'b1, 32'h1000);
    end
    cyc("bp.issue", 3'b111, 1'b1, 1'b0, 32'h0, RR ? 3'b010 : 3'b001, 3'b000, 1'b1, 32'h1000);
    req_valid = '0;
    #1;
    chk("bp.next_addr",  cache_addr,        RR ? 32'h1100 : 32'h1000);
    chk("bp.next_wdata", cache_wdata,       RR ? 32'hD1 : 32'hD0);
    chk("bp.next_wen",   32'(cache_wen),    RR ? 32'h1 : 32'h0);
    chk("bp.next_wmask", 32'(cache_wmask),  RR ? 32'h2 : 32'h1);
    @(posedge clk);
    @(negedge clk);

    // Response routing back to issuing ports, then a spurious response on an empty FIFO.
    do_reset();
    cyc("rt.acc1", 3'b010, 1'b1, 1'b0, 32'h0, 3'b010, 3'b000, 1'b0, 32'h0);
    cyc("rt.acc0", 3'b001, 1'b1, 1'b0, 32'h0, 3'b001, 3'b000, 1'b1, 32'h1100);
    cyc("rt.acc1b", 3'b010, 1'b1, 1'b0, 32'h0, 3'b010, 3'b000, 1'b1, 32'h1000);
    cyc("rt.rspA", 3'b000, 1'b1, 1'b1, 32'hA, 3'b000, 3'b010, 1'b1, 32'h1100);
    cyc("rt.rspB", 3'b000, 1'b1, 1'b1, 32'hB, 3'b000, 3'b001, 1'b0, 32'h1100);
    cyc("rt.rspC", 3'b000, 1'b1, 1'b1, 32'hC, 3'b000, 3'b010, 1'b0, 32'h1100);
    cyc("sp.rsp",  3'b000, 1'b1, 1'b1, 32'hD, 3'b000, 3'b000, 1'b0, 32'h1100);
    cyc("sp.acc2", 3'b100, 1'b1, 1'b0, 32'h0, 3'b100, 3'b000, 1'b0, 32'h1100);
    cyc("sp.rspE", 3'b000, 1'b1, 1'b1, 32'hE, 3'b000, 3'b100, 1'b1, 32'h1200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
